// File: rtl/frac_clken_gen_pkg.sv
// Shared widths, ratio payload type and named default ratios for the
// fractional clock-enable generator.
package frac_clken_gen_pkg;

  localparam int unsigned ACC_W_DEF    = 8;
  localparam int unsigned CHANNELS_MAX = 8;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] num;
    logic [ACC_W_DEF-1:0] den;
  } ratio_t;

  localparam int unsigned DIV4_NUM = 1;
  localparam int unsigned DIV4_DEN = 4;

  // Named ratios assume a 56 MHz system clock.
  localparam ratio_t DIV4     = '{num: ACC_W_DEF'(DIV4_NUM), den: ACC_W_DEF'(DIV4_DEN)};
  localparam ratio_t CPU_4M   = '{num: ACC_W_DEF'(1),        den: ACC_W_DEF'(14)};
  localparam ratio_t CRTC_14M = '{num: ACC_W_DEF'(1),        den: ACC_W_DEF'(4)};

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frac_clken_gen_ch.sv
// One fractional clock-enable channel: accumulator, live ratio, shadow ratio
// with pending flag, and the registered enable / square outputs.
module frac_clken_ch
  import frac_clken_gen_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned DEF_NUM = DIV4_NUM,
  parameter int unsigned DEF_DEN = DIV4_DEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [ACC_W-1:0] i_wr_num,
  input  logic [ACC_W-1:0] i_wr_den,
  output logic             o_pending,
  output logic             o_clken,
  output logic             o_clkout
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] r_acc, r_num, r_den, r_sh_num, r_sh_den;
  logic             r_pending, r_clken, r_clkout;

  logic [SUM_W-1:0] w_sum;
  logic             w_active, w_wrap, w_apply;
  logic [ACC_W-1:0] w_acc_step, w_acc_nxt, w_num_nxt, w_den_nxt;
  logic [ACC_W-1:0] w_sh_num_nxt, w_sh_den_nxt;
  logic             w_pending_nxt, w_clken_nxt, w_clkout_nxt;

  // Next-state: accumulate, wrap, shadow application and sync realignment.
  always_comb begin
    w_sum         = SUM_W'(r_acc) + SUM_W'(r_num);
    w_active      = i_run && (r_num != '0) && (r_den != '0) && (r_num <= r_den);
    w_wrap        = w_active && (w_sum >= SUM_W'(r_den));
    w_apply       = r_pending && (w_wrap || (i_run && !w_active));
    w_acc_step    = r_acc;
    w_acc_nxt     = r_acc;
    w_num_nxt     = r_num;
    w_den_nxt     = r_den;
    w_sh_num_nxt  = r_sh_num;
    w_sh_den_nxt  = r_sh_den;
    w_pending_nxt = r_pending;
    w_clken_nxt   = w_wrap;
    w_clkout_nxt  = r_clkout ^ w_wrap;

    if (w_wrap) begin
      w_acc_step = ACC_W'(w_sum - SUM_W'(r_den));
    end else if (w_active) begin
      w_acc_step = ACC_W'(w_sum);
    end
    w_acc_nxt = w_acc_step;

    if (i_sync) begin
      w_acc_nxt    = '0;
      w_clken_nxt  = 1'b0;
      w_clkout_nxt = 1'b0;
      if (r_pending) begin
        w_num_nxt = r_sh_num;
        w_den_nxt = r_sh_den;
      end
    end else if (w_apply) begin
      // The wrap on this cycle used the old ratio; clear acc if it no longer fits.
      w_num_nxt = r_sh_num;
      w_den_nxt = r_sh_den;
      if (w_acc_step >= r_sh_den) begin
        w_acc_nxt = '0;
      end
    end

    // A write always lands after any same-cycle application, so it stays pending.
    if (i_wr) begin
      w_sh_num_nxt  = i_wr_num;
      w_sh_den_nxt  = i_wr_den;
      w_pending_nxt = 1'b1;
    end else if (i_sync || w_apply) begin
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_num     <= ACC_W'(DEF_NUM);
      r_den     <= ACC_W'(DEF_DEN);
      r_sh_num  <= '0;
      r_sh_den  <= '0;
      r_pending <= 1'b0;
      r_clken   <= 1'b0;
      r_clkout  <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_num     <= w_num_nxt;
      r_den     <= w_den_nxt;
      r_sh_num  <= w_sh_num_nxt;
      r_sh_den  <= w_sh_den_nxt;
      r_pending <= w_pending_nxt;
      r_clken   <= w_clken_nxt;
      r_clkout  <= w_clkout_nxt;
    end
  end

  assign o_pending = r_pending;
  assign o_clken   = r_clken;
  assign o_clkout  = r_clkout;

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: config write decode and
// run/sync fan-out around an array of independent channels.
module frac_clken_gen
  import frac_clken_gen_pkg::*;
#(
  parameter  int unsigned CHANNELS = 2,
  parameter  int unsigned ACC_W    = ACC_W_DEF,
  parameter  int unsigned DEF_NUM  = DIV4_NUM,
  parameter  int unsigned DEF_DEN  = DIV4_DEN,
  localparam int unsigned CH_W     = ch_sel_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                sync,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] cfg_pending,
  output logic [CHANNELS-1:0] clken,
  output logic [CHANNELS-1:0] clkout
);

  logic [CHANNELS-1:0] w_wr;

  // Out-of-range channel numbers match no channel and are dropped.
  always_comb begin
    w_wr = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_wr[i] = cfg_wr && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    frac_clken_ch #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_run     (run),
      .i_sync    (sync),
      .i_wr      (w_wr[g]),
      .i_wr_num  (cfg_num),
      .i_wr_den  (cfg_den),
      .o_pending (cfg_pending[g]),
      .o_clken   (clken[g]),
      .o_clkout  (clkout[g])
    );
  end

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen: a per-cycle vector table for the default
// ratio, then hand-written sequences for ratio updates, sync, freeze and reset.
module tb_frac_clken_gen;
  import frac_clken_gen_pkg::*;

  localparam int unsigned CH = 2;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, run, sync, cfg_wr;
  logic [0:0]    cfg_ch;
  logic [AW-1:0] cfg_num, cfg_den;
  logic [CH-1:0] cfg_pending, clken, clkout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       run;
    logic       sync;
    logic [1:0] clken;
    logic [1:0] clkout;
  } vec_t;

  vec_t vecs [28];
  int   seq23 [6];
  int   seq34 [7];
  int   seq25 [5];

  frac_clken_gen #(
    .CHANNELS (CH),
    .ACC_W    (AW),
    .DEF_NUM  (1),
    .DEF_DEN  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sync        (sync),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_num     (cfg_num),
    .cfg_den     (cfg_den),
    .cfg_pending (cfg_pending),
    .clken       (clken),
    .clkout      (clkout)
  );

  always #5 clk = ~clk;

  // Ratios with num > den are out of range for this generator.
  always @(posedge clk) begin
    if (rst_n && cfg_wr) begin
      assert (cfg_num <= cfg_den) else $error("cfg write with num > den");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] ck, input logic [1:0] co);
    vec_t v;
    v.run = r; v.sync = s; v.clken = ck; v.clkout = co;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_cfg(input logic ch, input int n, input int d);
    cfg_wr  = 1'b1;
    cfg_ch  = ch;
    cfg_num = AW'(n);
    cfg_den = AW'(d);
  endtask

  initial begin
    int pulses, gap, bad_gap, acc_max, k, acc_v;

    // Default 1/4: pulse every 4th cycle, then freeze, then sync realign.
    vecs[0]  = mk(1, 0, 2'b00, 2'b00);  vecs[1]  = mk(1, 0, 2'b00, 2'b00);
    vecs[2]  = mk(1, 0, 2'b00, 2'b00);  vecs[3]  = mk(1, 0, 2'b11, 2'b11);
    vecs[4]  = mk(1, 0, 2'b00, 2'b11);  vecs[5]  = mk(1, 0, 2'b00, 2'b11);
    vecs[6]  = mk(1, 0, 2'b00, 2'b11);  vecs[7]  = mk(1, 0, 2'b11, 2'b00);
    vecs[8]  = mk(1, 0, 2'b00, 2'b00);  vecs[9]  = mk(1, 0, 2'b00, 2'b00);
    vecs[10] = mk(1, 0, 2'b00, 2'b00);  vecs[11] = mk(1, 0, 2'b11, 2'b11);
    vecs[12] = mk(1, 0, 2'b00, 2'b11);  vecs[13] = mk(1, 0, 2'b00, 2'b11);
    vecs[14] = mk(1, 0, 2'b00, 2'b11);  vecs[15] = mk(1, 0, 2'b11, 2'b00);
    vecs[16] = mk(1, 0, 2'b00, 2'b00);  vecs[17] = mk(0, 0, 2'b00, 2'b00);
    vecs[18] = mk(0, 0, 2'b00, 2'b00);  vecs[19] = mk(1, 0, 2'b00, 2'b00);
    vecs[20] = mk(1, 0, 2'b00, 2'b00);  vecs[21] = mk(1, 0, 2'b11, 2'b11);
    vecs[22] = mk(1, 1, 2'b00, 2'b00);  vecs[23] = mk(1, 0, 2'b00, 2'b00);
    vecs[24] = mk(1, 0, 2'b00, 2'b00);  vecs[25] = mk(1, 0, 2'b00, 2'b00);
    vecs[26] = mk(1, 0, 2'b11, 2'b11);  vecs[27] = mk(1, 0, 2'b00, 2'b11);
    seq23 = '{0, 1, 1, 0, 1, 1};
    seq34 = '{0, 1, 0, 1, 1, 1, 0};
    seq25 = '{0, 0, 1, 0, 1};

    rst_n = 1'b0; run = 1'b0; sync = 1'b0;
    cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_num = '0; cfg_den = '0;
    tick(); tick();
    chk("reset_clken", 32'(clken), 0);
    chk("reset_clkout", 32'(clkout), 0);
    chk("reset_pending", 32'(cfg_pending), 0);

    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      run  = vecs[i].run;
      sync = vecs[i].sync;
      tick();
      chk($sformatf("tbl%0d_clken", i + 1), 32'(clken), 32'(vecs[i].clken));
      chk($sformatf("tbl%0d_clkout", i + 1), 32'(clkout), 32'(vecs[i].clkout));
    end
    run = 1'b1; sync = 1'b0;

    // Ch0 16/57 over 570 cycles from a synced start.
    put_cfg(1'b0, 16, 57); tick(); cfg_wr = 1'b0;
    chk("p1657_pending_set", 32'(cfg_pending), 1);
    sync = 1'b1; tick(); sync = 1'b0;
    chk("p1657_pending_clr", 32'(cfg_pending), 0);
    pulses = 0; gap = 0; bad_gap = 0; acc_max = 0;
    for (int i = 0; i < 570; i++) begin
      tick();
      gap++;
      acc_v = int'(dut.g_ch[0].u_ch.r_acc);
      if (acc_v > acc_max) acc_max = acc_v;
      if (clken[0]) begin
        pulses++;
        if (gap < 3 || gap > 4) bad_gap++;
        gap = 0;
      end
    end
    chk("p1657_pulses", 32'(pulses), 160);
    chk("p1657_bad_spacing", 32'(bad_gap), 0);
    chk("p1657_acc_below_den", 32'(acc_max < 57), 1);

    // Ch1 3/3: enable every cycle once applied.
    put_cfg(1'b1, 3, 3); tick(); cfg_wr = 1'b0;
    chk("p33_pending_set", 32'(cfg_pending[1]), 1);
    k = 0;
    while (cfg_pending[1] && k < 8) begin tick(); k++; end
    chk("p33_applied", 32'(cfg_pending[1]), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (clken[1]) pulses++; end
    chk("p33_every_cycle", 32'(pulses), 8);

    // Ch1 0/3: last wrap uses 3/3, then the channel goes idle.
    put_cfg(1'b1, 0, 3); tick(); cfg_wr = 1'b0;
    chk("p03_pending", 32'(cfg_pending[1]), 1);
    chk("p03_clken_w", 32'(clken[1]), 1);
    tick();
    chk("p03_pending_clr", 32'(cfg_pending[1]), 0);
    chk("p03_clken_last", 32'(clken[1]), 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (clken[1]) pulses++; end
    chk("p03_idle_quiet", 32'(pulses), 0);

    // Idle channel applies a new ratio on the next cycle.
    put_cfg(1'b1, 1, 2); tick(); cfg_wr = 1'b0;
    chk("idle_apply_pending", 32'(cfg_pending[1]), 1);
    tick();
    chk("idle_apply_clr", 32'(cfg_pending[1]), 0);

    // Ch0 7/10 written at acc=2 under 1/4.
    put_cfg(1'b0, 1, 4); tick(); cfg_wr = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    tick(); tick();
    put_cfg(1'b0, 7, 10); tick(); cfg_wr = 1'b0;
    chk("p710_pending", 32'(cfg_pending[0]), 1);
    chk("p710_no_wrap_yet", 32'(clken[0]), 0);
    tick();
    chk("p710_old_wrap", 32'(clken[0]), 1);
    chk("p710_applied", 32'(cfg_pending[0]), 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (clken[0]) pulses++; end
    chk("p710_pulses", 32'(pulses), 70);

    // Sync applies ch1's pending ratio; a write during sync stays pending.
    put_cfg(1'b1, 2, 5); tick(); cfg_wr = 1'b0;
    chk("sync_pre_pending", 32'(cfg_pending[1]), 1);
    put_cfg(1'b0, 1, 4); sync = 1'b1; tick(); sync = 1'b0; cfg_wr = 1'b0;
    chk("sync_pending", 32'(cfg_pending), 1);
    chk("sync_clken", 32'(clken), 0);
    chk("sync_clkout", 32'(clkout), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sync_p25_c%0d", i + 1), 32'(clken[1]), 32'(seq25[i]));
      if (i == 0) chk("sync_wr_stays", 32'(cfg_pending[0]), 1);
    end
    chk("sync_p25_clkout", 32'(clkout[1]), 0);

    // Ch0 2/3 written while acc=3 under 1/4.
    put_cfg(1'b0, 1, 4); tick(); cfg_wr = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    tick(); tick();
    put_cfg(1'b0, 2, 3); tick(); cfg_wr = 1'b0;
    chk("p23_pending", 32'(cfg_pending[0]), 1);
    tick();
    chk("p23_wrap", 32'(clken[0]), 1);
    chk("p23_acc_zero", 32'(dut.g_ch[0].u_ch.r_acc), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("p23_c%0d", i + 1), 32'(clken[0]), 32'(seq23[i]));
    end

    // 3/4 -> 1/2 with acc clear, and a write landing on the apply cycle.
    put_cfg(1'b0, 3, 4); tick(); cfg_wr = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    put_cfg(1'b0, 1, 2); tick();
    chk("clr_pending", 32'(cfg_pending[0]), 1);
    chk("clr_e1_clken", 32'(clken[0]), 0);
    put_cfg(1'b0, 3, 4); tick(); cfg_wr = 1'b0;
    chk("clr_e2_clken", 32'(clken[0]), 1);
    chk("clr_e2_repending", 32'(cfg_pending[0]), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("clr_e%0d", i + 3), 32'(clken[0]), 32'(seq34[i]));
      if (i == 0) chk("clr_e3_pending", 32'(cfg_pending[0]), 1);
      if (i == 1) chk("clr_e4_pending", 32'(cfg_pending[0]), 0);
    end

    // run=0 for 20 cycles freezes the channel.
    run = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (clken[0]) pulses++; end
    chk("frz_no_clken", 32'(pulses), 0);
    chk("frz_acc_held", 32'(dut.g_ch[0].u_ch.r_acc), 3);
    chk("frz_clkout_held", 32'(clkout[0]), 1);
    run = 1'b1;
    tick();
    chk("frz_r1_clken", 32'(clken[0]), 1);
    chk("frz_r1_clkout", 32'(clkout[0]), 0);
    tick();
    chk("frz_r2_clken", 32'(clken[0]), 1);
    chk("frz_r2_clkout", 32'(clkout[0]), 1);

    // Asynchronous reset mid-stream, then default 1/4 timing again.
    run = 1'b0;
    put_cfg(1'b1, 1, 3); tick(); cfg_wr = 1'b0;
    chk("rst_pre_pending", 32'(cfg_pending), 2);
    chk("rst_pre_clkout", 32'(clkout[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_clken", 32'(clken), 0);
    chk("rst_async_clkout", 32'(clkout), 0);
    chk("rst_async_pending", 32'(cfg_pending), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rst_post_c%0d", i + 1), 32'(clken), (i == 3) ? 3 : 0);
    end
    chk("rst_post_clkout", 32'(clkout), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
